// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame
// constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit from the XOR-reduction of the data word; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timing for the UART transmitter: an edge counter that spans one bit
// period of Prescale cycles and a bit counter that walks the data bits.
module tx_bit_timer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,      // frame accepted: latch prescale, clear counters
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   run,       // count while a frame is in progress
  input  logic                   bit_step,  // advance the data bit counter
  output logic                   tick,      // last cycle of the current bit period
  output logic                   bit_last   // current data bit is the final one
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] edge_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [PRESC_WIDTH-1:0] presc_last;

  // Prescale of zero wraps to all-ones here, giving 2**PRESC_WIDTH cycles per bit.
  assign presc_last = presc_q - PRESC_ONE;
  assign tick       = run && (edge_cnt == presc_last);
  assign bit_last   = (bit_cnt == BIT_LAST);

  // Edge counter and latched prescale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      edge_cnt <= '0;
    end else if (load) begin
      presc_q  <= prescale;
      edge_cnt <= '0;
    end else if (run) begin
      edge_cnt <= tick ? '0 : edge_cnt + PRESC_ONE;
    end
  end

  // Data bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else if (bit_step) begin
      bit_cnt <= bit_last ? '0 : bit_cnt + BIT_ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit; every bit held for Prescale clock cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy
);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  accept;
  logic                  tick;
  logic                  bit_last;
  logic                  bit_step;

  assign accept = (state_q == IDLE) && Data_Valid;

  tx_bit_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (RST),
    .load     (accept),
    .prescale (Prescale),
    .run      (busy_q),
    .bit_step (bit_step),
    .tick     (tick),
    .bit_last (bit_last)
  );

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Registered line, busy flag, shift register and latched frame options.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state and next-register values; the line value for each bit is
  // computed one cycle early so TX_OUT comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    bit_step  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (Data_Valid) begin
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          shreg_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = parity_bit(^P_DATA, PAR_TYP);
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end

      DATA: begin
        if (tick) begin
          bit_step = 1'b1;
          if (bit_last) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-written expected frames,
// a monitor checks every bit cycle of each frame as the DUT emits it.
module tb_uart_tx;

  logic       clk;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // bits: character i is the i-th bit on the line ("0"/"1"); cyc: cycles per bit.
  typedef struct {
    string bits;
    int    cyc;
    bit    abort_ok;
    string name;
  } exp_t;

  exp_t exp_q[$];

  uart_tx #(
    .DATA_WIDTH  (8),
    .PRESC_WIDTH (6)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input string b, input int c, input bit a, input string n);
    exp_t e;
    e.bits     = b;
    e.cyc      = c;
    e.abort_ok = a;
    e.name     = n;
    return e;
  endfunction

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps, input bit expect_accept, input string nm);
    @(posedge clk);
    #1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    // Scramble inputs: they must not matter once the frame is accepted.
    P_DATA   = ~d;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    Prescale = ps + 6'd3;
    if (expect_accept) chk({nm, " accept"}, {30'b0, busy, TX_OUT}, 32'h2);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk({nm, " idle timeout"}, {31'b0, busy}, 32'h0);
  endtask

  // Monitor: checks each cycle of every frame against the queued expectation.
  initial begin : monitor
    exp_t e;
    int   mism;
    int   n;
    logic expb;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && RST === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected frame", {31'b0, busy}, 32'h0);
          n = 0;
          while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          e = exp_q.pop_front();
          aborted = 1'b0;
          for (int i = 0; i < e.bits.len() && !aborted; i++) begin
            expb = (e.bits.getc(i) == 8'h31);
            mism = 0;
            for (int j = 0; j < e.cyc && !aborted; j++) begin
              if (i != 0 || j != 0) @(negedge clk);
              if (RST === 1'b1) aborted = 1'b1;
              else if (TX_OUT !== expb || busy !== 1'b1) mism++;
            end
            if (!aborted) chk($sformatf("%s bit %0d", e.name, i), mism, 0);
          end
          chk({e.name, " abort"}, {31'b0, aborted}, {31'b0, e.abort_ok});
          if (!aborted) begin
            @(negedge clk);
            chk({e.name, " end"}, {30'b0, busy, TX_OUT}, 32'h1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    int mism;
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {30'b0, busy, TX_OUT}, 32'h1);
    RST = 1'b0;
    repeat (2) @(posedge clk);

    // 0xA5, even parity, 8 cycles/bit.
    exp_q.push_back(mk("01010010101", 8, 1'b0, "a5_even_p8"));
    send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b1, "a5");
    wait_idle("a5");

    // 0x00, odd parity, 16 cycles/bit.
    exp_q.push_back(mk("00000000011", 16, 1'b0, "00_odd_p16"));
    send(8'h00, 1'b1, 1'b1, 6'd16, 1'b1, "00");
    wait_idle("00");

    // 0xFF, no parity, 16 cycles/bit; strobe on the busy-falling edge is ignored.
    exp_q.push_back(mk("0111111111", 16, 1'b0, "ff_nopar_p16"));
    send(8'hFF, 1'b0, 1'b0, 6'd16, 1'b1, "ff");
    repeat (159) @(posedge clk);
    #1;
    P_DATA     = 8'h11;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    mism = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) mism++;
    end
    chk("coincident strobe ignored", mism, 0);

    // 0x3C with a mid-frame strobe that must be dropped, then back-to-back 0xC3.
    exp_q.push_back(mk("00011110001", 8, 1'b0, "3c_even_p8"));
    send(8'h3C, 1'b1, 1'b0, 6'd8, 1'b1, "3c");
    repeat (30) @(posedge clk);
    send(8'hC3, 1'b0, 1'b1, 6'd4, 1'b0, "c3_dropped");
    wait_idle("3c");
    exp_q.push_back(mk("0110000111", 4, 1'b0, "c3_nopar_p4"));
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    chk("c3 back-to-back accept", {30'b0, busy, TX_OUT}, 32'h2);
    wait_idle("c3");

    // Reset during data bit 4 of a 0x5A frame.
    exp_q.push_back(mk("00101101001", 8, 1'b1, "5a_reset"));
    send(8'h5A, 1'b1, 1'b0, 6'd8, 1'b1, "5a");
    repeat (43) @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    chk("async reset", {30'b0, busy, TX_OUT}, 32'h1);
    repeat (3) @(posedge clk);
    #2;
    RST = 1'b0;
    mism = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) mism++;
    end
    chk("idle after reset", mism, 0);
    exp_q.push_back(mk("00110100111", 8, 1'b0, "96_odd_p8"));
    send(8'h96, 1'b1, 1'b1, 6'd8, 1'b1, "96");
    wait_idle("96");

    // Prescale 0 means 64 cycles per bit.
    exp_q.push_back(mk("0100000001", 64, 1'b0, "01_nopar_p0"));
    send(8'h01, 1'b0, 1'b0, 6'd0, 1'b1, "01");
    wait_idle("01");

    repeat (5) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter forming the transmit half of the serial link. It accepts a parallel byte with a one-cycle valid strobe and serialises it on TX_OUT as: start bit, 8 data bits LSB first, optional parity bit, stop bit. It runs on the same oversampled clock as the receive path. Every bit is held for Prescale clock cycles, so TX and RX share one clock and one Prescale setting.

Parameters:
DATA_WIDTH, 8, data bits per frame.
PRESC_WIDTH, 6, width of the Prescale input and of the edge counter.

Ports:
clk  input  1  system clock, oversampled bit clock.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  byte to transmit; sampled only when accepted.
Data_Valid  input  1  single-cycle strobe requesting transmission of P_DATA.
PAR_EN  input  1  1 = insert parity bit; sampled at accept.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at accept.
Prescale  input  PRESC_WIDTH  clk cycles per bit; sampled at accept.
TX_OUT  output  1  serial line, registered, idle high.
busy  output  1  high while a frame is in progress, registered.

Behaviour:
- Reset (asynchronous, at any time, including mid-frame):
  - TX_OUT=1, busy=0, FSM=IDLE, counters=0, shift register=0.
  - A frame interrupted by reset is abandoned and is not resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept rule: Data_Valid=1 at a rising edge while in IDLE accepts the request.
  - Captured on that edge: P_DATA, PAR_EN, PAR_TYP, Prescale, and parity (XOR of P_DATA, inverted when PAR_TYP=1).
  - On that same edge: FSM→START, TX_OUT←0, busy←1.
  - TX_OUT therefore changes 1 cycle after the strobe.
- Data_Valid outside IDLE is ignored; no queueing. Input changes mid-frame have no effect.
- Bit timing: the edge counter runs 0..Prescale_latched-1, and each bit is held exactly Prescale_latched cycles.
  - Prescale=0 means 64 cycles per bit (6-bit wrap). Prescale=1 means 1 cycle per bit.
- Transitions, taken at edge-counter terminal count:
  - START→DATA, with TX_OUT←data[0].
  - DATA shifts through bits 0..7 using the bit counter. After bit 7: →PARITY if PAR_EN latched, else →STOP.
  - PARITY→STOP, with TX_OUT←1.
  - STOP terminal count→IDLE, with busy←0 and TX_OUT stays 1.
- Frame length in busy-high cycles: 11*P with parity, 10*P without.
- Back-to-back frames:
  - The earliest accept is the edge after busy falls, giving a minimum 1-cycle idle-high gap between frames.
  - A Data_Valid coinciding with the edge where busy falls is ignored.
- TX_OUT is glitch-free: driven directly from a flop, never from combinational logic.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - constants UART_DATA_BITS=8 and UART_STOP_BITS=1;
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module, tx_bit_timer, contains:
  - the edge counter and bit counter;
  - a terminal-count pulse, reload on accept, clear on RST.
- The FSM, shift register and parity generation live in uart_tx.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one strobe → TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; busy high 88 cycles; TX_OUT falls 1 cycle after the strobe.
- Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x00 → 0, eight 0s, parity bit 1, stop bit 1; busy high 176 cycles.
- Prescale=16, PAR_EN=0, P_DATA=0xFF → 0, eight 1s, stop bit 1; busy high 160 cycles; no parity slot.
- Strobe 0x3C, then mid-frame a strobe with P_DATA=0xC3 plus changes to Prescale and PAR_EN → the first frame is transmitted unchanged and the second strobe is dropped. A strobe 1 cycle after busy falls → 0xC3 frame starts with exactly a 1-cycle idle gap.
- Assert RST during data bit 4 of a frame → TX_OUT=1 and busy=0 immediately (asynchronous). After release, the line stays idle high until a new strobe arrives, and the next frame is correct.
- Prescale=0, PAR_EN=0, P_DATA=0x01 → each bit lasts 64 cycles; busy high 640 cycles.
